// File: rtl/axi_rt_resp_meter.sv
// Passive AXI response-side meter: per-period read byte and B counts against a
// read budget, plus outstanding-read tracking with a high-water mark.
module axi_rt_resp_meter #(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned PeriodWidth = 32,
    parameter int unsigned BudgetWidth = 32,
    parameter int unsigned NumPending  = 16,
    localparam int unsigned OutWidth   = ((NumPending > 1) ? $clog2(NumPending) : 1) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   abort_i,
    input  logic [PeriodWidth-1:0] period_i,
    input  logic [BudgetWidth-1:0] r_budget_i,
    input  logic                   ar_valid_i,
    input  logic                   ar_ready_i,
    input  logic                   r_valid_i,
    input  logic                   r_ready_i,
    input  logic                   r_last_i,
    input  logic                   b_valid_i,
    input  logic                   b_ready_i,
    output logic [PeriodWidth-1:0] period_left_o,
    output logic [BudgetWidth-1:0] r_bytes_o,
    output logic [BudgetWidth-1:0] r_bytes_last_o,
    output logic [BudgetWidth-1:0] b_count_last_o,
    output logic                   r_budget_spent_o,
    output logic [OutWidth-1:0]    rd_outstanding_o,
    output logic [OutWidth-1:0]    rd_outstanding_max_o,
    output logic                   protocol_error_o
);

    localparam int unsigned BeatBytes = DataWidth / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PeriodWidth-1:0] period_left_q, period_left_d;
    logic [BudgetWidth-1:0] r_acc_q, r_acc_d;
    logic [BudgetWidth-1:0] b_acc_q, b_acc_d;
    logic [BudgetWidth-1:0] r_last_q, r_last_d;
    logic [BudgetWidth-1:0] b_last_q, b_last_d;
    logic [OutWidth-1:0]    out_q;
    logic [OutWidth-1:0]    out_max_q;
    logic                   err_q;

    logic                   ar_hs;
    logic                   r_hs;
    logic                   rl_hs;
    logic                   b_hs;
    logic [BudgetWidth-1:0] r_inc;
    logic [BudgetWidth-1:0] b_inc;
    logic [BudgetWidth-1:0] r_sum;
    logic [BudgetWidth-1:0] b_sum;
    logic [PeriodWidth-1:0] reload;

    // Accumulator add that sticks at all-ones instead of wrapping
    function automatic logic [BudgetWidth-1:0] sat_add(input logic [BudgetWidth-1:0] a,
                                                       input logic [BudgetWidth-1:0] b);
        logic [BudgetWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[BudgetWidth] ? '1 : s[BudgetWidth-1:0];
    endfunction

    assign ar_hs  = ar_valid_i & ar_ready_i;
    assign r_hs   = r_valid_i & r_ready_i;
    assign rl_hs  = r_hs & r_last_i;
    assign b_hs   = b_valid_i & b_ready_i;
    assign r_inc  = r_hs ? BudgetWidth'(BeatBytes) : '0;
    assign b_inc  = b_hs ? BudgetWidth'(1) : '0;
    assign r_sum  = sat_add(r_acc_q, r_inc);
    assign b_sum  = sat_add(b_acc_q, b_inc);
    assign reload = (period_i == '0) ? PeriodWidth'(1) : period_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and period/accumulator updates; disable beats abort beats rollover
    always_comb begin
        state_d       = state_q;
        period_left_d = period_left_q;
        r_acc_d       = r_acc_q;
        b_acc_d       = b_acc_q;
        r_last_d      = r_last_q;
        b_last_d      = b_last_q;
        case (state_q)
            IDLE: begin
                period_left_d = '0;
                r_acc_d       = '0;
                b_acc_d       = '0;
                if (enable_i) begin
                    state_d       = RUN;
                    period_left_d = reload;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d       = IDLE;
                    period_left_d = '0;
                    r_acc_d       = '0;
                    b_acc_d       = '0;
                end else if (abort_i) begin
                    period_left_d = reload;
                    r_acc_d       = '0;
                    b_acc_d       = '0;
                end else if (period_left_q == PeriodWidth'(1)) begin
                    r_last_d      = r_sum;
                    b_last_d      = b_sum;
                    period_left_d = reload;
                    r_acc_d       = '0;
                    b_acc_d       = '0;
                end else begin
                    period_left_d = period_left_q - PeriodWidth'(1);
                    r_acc_d       = r_sum;
                    b_acc_d       = b_sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Period counter, running accumulators and last-period snapshots
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            period_left_q <= '0;
            r_acc_q       <= '0;
            b_acc_q       <= '0;
            r_last_q      <= '0;
            b_last_q      <= '0;
        end else begin
            period_left_q <= period_left_d;
            r_acc_q       <= r_acc_d;
            b_acc_q       <= b_acc_d;
            r_last_q      <= r_last_d;
            b_last_q      <= b_last_d;
        end
    end

    // Outstanding reads, high-water mark and sticky underflow flag (ignores enable)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q     <= '0;
            out_max_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (ar_hs && !rl_hs) begin
                if (out_q != OutWidth'(NumPending)) out_q <= out_q + OutWidth'(1);
            end else if (rl_hs && !ar_hs) begin
                if (out_q == '0) err_q <= 1'b1;
                else             out_q <= out_q - OutWidth'(1);
            end
            if (out_q > out_max_q) out_max_q <= out_q;
        end
    end

    assign period_left_o        = period_left_q;
    assign r_bytes_o            = r_acc_q;
    assign r_bytes_last_o       = r_last_q;
    assign b_count_last_o       = b_last_q;
    assign r_budget_spent_o     = (state_q == RUN) && (r_acc_q >= r_budget_i);
    assign rd_outstanding_o     = out_q;
    assign rd_outstanding_max_o = out_max_q;
    assign protocol_error_o     = err_q;

endmodule

// File: tb/tb_axi_rt_resp_meter.sv
// Directed bench for axi_rt_resp_meter (DataWidth 64 -> 8 bytes per beat).
module tb_axi_rt_resp_meter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        abort;
    logic [31:0] period;
    logic [31:0] budget;
    logic        ar_valid, ar_ready;
    logic        r_valid, r_ready, r_last;
    logic        b_valid, b_ready;
    logic [31:0] period_left;
    logic [31:0] r_bytes;
    logic [31:0] r_bytes_last;
    logic [31:0] b_count_last;
    logic        spent;
    logic [4:0]  outst;
    logic [4:0]  outst_max;
    logic        perr;

    int total = 0;
    int passed = 0;

    axi_rt_resp_meter #(
        .DataWidth  (64),
        .PeriodWidth(32),
        .BudgetWidth(32),
        .NumPending (16)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .enable_i            (enable),
        .abort_i             (abort),
        .period_i            (period),
        .r_budget_i          (budget),
        .ar_valid_i          (ar_valid),
        .ar_ready_i          (ar_ready),
        .r_valid_i           (r_valid),
        .r_ready_i           (r_ready),
        .r_last_i            (r_last),
        .b_valid_i           (b_valid),
        .b_ready_i           (b_ready),
        .period_left_o       (period_left),
        .r_bytes_o           (r_bytes),
        .r_bytes_last_o      (r_bytes_last),
        .b_count_last_o      (b_count_last),
        .r_budget_spent_o    (spent),
        .rd_outstanding_o    (outst),
        .rd_outstanding_max_o(outst_max),
        .protocol_error_o    (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles; inputs and checks happen 1 time unit after each edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_r(input logic v, input logic last);
        r_valid = v;
        r_ready = v;
        r_last  = last;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; abort = 1'b0;
        period = 32'd10; budget = 32'd1000;
        ar_valid = 1'b0; ar_ready = 1'b0;
        set_r(1'b0, 1'b0);
        b_valid = 1'b0; b_ready = 1'b0;
        step(2);

        // Reset state
        chk("rst_period_left", period_left, 0);
        chk("rst_r_bytes", r_bytes, 0);
        chk("rst_r_bytes_last", r_bytes_last, 0);
        chk("rst_b_count_last", b_count_last, 0);
        chk("rst_spent", spent, 0);
        chk("rst_outst", outst, 0);
        chk("rst_outst_max", outst_max, 0);
        chk("rst_perr", perr, 0);
        rst_n = 1'b1;
        step(1);
        chk("idle_period_left", period_left, 0);

        // Three beats, then rollover snapshot
        enable = 1'b1;
        step(1);
        chk("run_load", period_left, 10);
        step(1);
        set_r(1'b1, 1'b0);
        step(3);
        set_r(1'b0, 1'b0);
        chk("t1_r_bytes", r_bytes, 24);
        chk("t1_period_left", period_left, 6);
        step(5);
        chk("t1_pre_roll", period_left, 1);
        step(1);
        chk("t1_r_last", r_bytes_last, 24);
        chk("t1_r_bytes_clr", r_bytes, 0);
        chk("t1_reload", period_left, 10);

        // Budget crossing
        budget = 32'd16;
        #1;
        chk("t2_spent_0", spent, 0);
        set_r(1'b1, 1'b0);
        step(1);
        chk("t2_spent_1beat", spent, 0);
        step(1);
        set_r(1'b0, 1'b0);
        chk("t2_spent_2beat", spent, 1);
        step(7);
        chk("t2_spent_hold", spent, 1);
        step(1);
        chk("t2_spent_roll", spent, 0);
        chk("t2_r_last", r_bytes_last, 16);
        budget = 32'd0;
        #1;
        chk("t2_budget0", spent, 1);
        budget = 32'd1000;
        #1;
        chk("t2_budget_back", spent, 0);

        // Traffic in the rollover cycle belongs to the closing period
        b_valid = 1'b1; b_ready = 1'b1;
        step(1);
        b_valid = 1'b0; b_ready = 1'b0;
        step(8);
        chk("t3_pre_roll", period_left, 1);
        set_r(1'b1, 1'b0);
        b_valid = 1'b1; b_ready = 1'b1;
        step(1);
        set_r(1'b0, 1'b0);
        b_valid = 1'b0; b_ready = 1'b0;
        chk("t3_r_last", r_bytes_last, 8);
        chk("t3_b_last", b_count_last, 2);
        chk("t3_r_bytes_new", r_bytes, 0);
        chk("t3_reload", period_left, 10);

        // Abort restarts the period without touching snapshots
        set_r(1'b1, 1'b0);
        step(2);
        set_r(1'b0, 1'b0);
        step(2);
        chk("t4_pre_abort_bytes", r_bytes, 16);
        chk("t4_pre_abort_left", period_left, 6);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t4_reload", period_left, 10);
        chk("t4_r_bytes", r_bytes, 0);
        chk("t4_r_last_hold", r_bytes_last, 8);
        chk("t4_b_last_hold", b_count_last, 2);

        // Outstanding read tracking
        ar_valid = 1'b1; ar_ready = 1'b1;
        step(3);
        ar_valid = 1'b0; ar_ready = 1'b0;
        chk("t5_outst3", outst, 3);
        chk("t5_max_lag", outst_max, 2);
        step(1);
        chk("t5_max3", outst_max, 3);
        ar_valid = 1'b1; ar_ready = 1'b1;
        set_r(1'b1, 1'b1);
        step(1);
        ar_valid = 1'b0; ar_ready = 1'b0;
        chk("t5_ar_and_last", outst, 3);
        step(3);
        chk("t5_drained", outst, 0);
        chk("t5_no_err", perr, 0);
        step(1);
        set_r(1'b0, 1'b0);
        chk("t5_underflow_outst", outst, 0);
        chk("t5_perr", perr, 1);
        chk("t5_max_hold", outst_max, 3);
        chk("t5_bytes40", r_bytes, 40);
        chk("t5_left1", period_left, 1);

        // Synchronous reset mid-period
        rst_n = 1'b0;
        step(1);
        chk("t6_left", period_left, 0);
        chk("t6_r_bytes", r_bytes, 0);
        chk("t6_r_last", r_bytes_last, 0);
        chk("t6_b_last", b_count_last, 0);
        chk("t6_perr", perr, 0);
        chk("t6_outst_max", outst_max, 0);
        chk("t6_spent", spent, 0);
        rst_n = 1'b1;
        step(1);
        chk("t6_fresh_left", period_left, 10);
        chk("t6_fresh_bytes", r_bytes, 0);

        // Disable returns to IDLE; zero period behaves as one
        enable = 1'b0;
        step(1);
        chk("t7_idle_left", period_left, 0);
        period = 32'd0;
        enable = 1'b1;
        step(1);
        chk("t7_period0_load", period_left, 1);
        set_r(1'b1, 1'b0);
        step(1);
        set_r(1'b0, 1'b0);
        chk("t7_period0_reload", period_left, 1);
        chk("t7_period0_last", r_bytes_last, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
